// File: rtl/vga_pkg.sv
// Shared VGA constants, the 6-bit RRGGBB colour type and the box palette.
package vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;

  typedef logic [5:0] rgb_t;

  typedef enum logic {
    DIR_INC,
    DIR_DEC
  } dir_e;

  localparam rgb_t BLACK  = 6'b000000;
  localparam rgb_t WHITE  = 6'b111111;
  localparam rgb_t RED    = 6'b110000;
  localparam rgb_t GREEN  = 6'b001100;
  localparam rgb_t BLUE   = 6'b000011;
  localparam rgb_t YELLOW = 6'b111100;

  function automatic rgb_t palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return RED;
      2'd1:    return GREEN;
      2'd2:    return BLUE;
      default: return YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/vga_bounce_renderer_bounce_axis.sv
// One axis of box motion: steps by SPEED per frame and reflects at 0 and LIMIT.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int unsigned LIMIT = 608,
  parameter int unsigned SPEED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [9:0] pos,
  output logic       bounce
);

  localparam logic [9:0] LIM = 10'(LIMIT);
  localparam logic [9:0] SPD = 10'(SPEED);

  logic [9:0] pos_q, pos_d, nxt_inc;
  dir_e       dir_q, dir_d;

  // bounce is a same-cycle pulse so the colour index advances on the tick edge
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    bounce  = 1'b0;
    nxt_inc = pos_q + SPD;
    if (step) begin
      if (dir_q == DIR_INC) begin
        if (nxt_inc >= LIM) begin
          pos_d  = LIM;
          dir_d  = DIR_DEC;
          bounce = 1'b1;
        end else begin
          pos_d = nxt_inc;
        end
      end else begin
        if (pos_q <= SPD) begin
          pos_d  = '0;
          dir_d  = DIR_INC;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q - SPD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_bounce_renderer.sv
// Pixel-colour stage: bouncing box over a white-bordered black field, 2-cycle
// pipeline with sync outputs aligned to rgb.
module vga_bounce_renderer
  import vga_pkg::rgb_t, vga_pkg::palette, vga_pkg::WHITE, vga_pkg::BLACK;
#(
  parameter int unsigned H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int unsigned BOX_W     = 32,
  parameter int unsigned BOX_H     = 32,
  parameter int unsigned SPEED     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [5:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_LAST = 10'(H_DISPLAY - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY - 1);
  localparam logic [9:0] V_VBL  = 10'(V_DISPLAY);
  localparam logic [9:0] BW     = 10'(BOX_W);
  localparam logic [9:0] BH     = 10'(BOX_H);

  logic       frame_tick, step, bounce_x, bounce_y;
  logic [9:0] box_x, box_y;
  logic [1:0] colour_idx_q;
  logic [7:0] frame_count_q;
  logic       in_box_d, border_d;
  logic       in_box_q, border_q, active_q, hs_q, vs_q;
  rgb_t       rgb_d, rgb_q;
  logic       hsync_q, vsync_q;

  assign frame_tick = (x == '0) && (y == V_VBL);
  assign step       = frame_tick && !pause;

  bounce_axis #(.LIMIT(H_DISPLAY - BOX_W), .SPEED(SPEED)) u_axis_x (
    .clk(clk), .rst(rst), .step(step), .pos(box_x), .bounce(bounce_x)
  );

  bounce_axis #(.LIMIT(V_DISPLAY - BOX_H), .SPEED(SPEED)) u_axis_y (
    .clk(clk), .rst(rst), .step(step), .pos(box_y), .bounce(bounce_y)
  );

  always_comb begin
    in_box_d = (x >= box_x) && (x < box_x + BW) && (y >= box_y) && (y < box_y + BH);
    border_d = (x == '0) || (x == H_LAST) || (y == '0) || (y == V_LAST);
    rgb_d    = BLACK;
    if (active_q) begin
      if (in_box_q)      rgb_d = palette(colour_idx_q);
      else if (border_q) rgb_d = WHITE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= '0;
      colour_idx_q  <= '0;
      in_box_q      <= 1'b0;
      border_q      <= 1'b0;
      active_q      <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      rgb_q         <= BLACK;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      if (frame_tick) frame_count_q <= frame_count_q + 8'd1;
      // a corner hit bounces both axes but advances the colour only once
      if (bounce_x || bounce_y) colour_idx_q <= colour_idx_q + 2'd1;
      in_box_q <= in_box_d;
      border_q <= border_d;
      active_q <= active;
      hs_q     <= hsync_in;
      vs_q     <= vsync_in;
      rgb_q    <= rgb_d;
      hsync_q  <= hs_q;
      vsync_q  <= vs_q;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Randomized bench for vga_bounce_renderer against a frame-level box model.
module tb_vga_bounce_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic       active, hsync_in, vsync_in, pause;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out;
  logic [7:0] frame_count;

  int unsigned errs = 0;
  int unsigned checks = 0;

  int bx, by, dx, dy, cidx, fc;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  vga_bounce_renderer #(
    .H_DISPLAY(640), .V_DISPLAY(480), .BOX_W(32), .BOX_H(32), .SPEED(2)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_count(frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pal(input int i);
    case (i)
      0:       return 6'b110000;
      1:       return 6'b001100;
      2:       return 6'b000011;
      default: return 6'b111100;
    endcase
  endfunction

  function automatic logic [7:0] model_out(input int px, input int py,
                                           input logic act, input logic hs, input logic vs);
    logic [5:0] c;
    bit inbox, border;
    inbox  = px >= bx && px < bx + 32 && py >= by && py < by + 32;
    border = px == 0 || px == 639 || py == 0 || py == 479;
    c = 6'b000000;
    if (act) c = inbox ? pal(cidx) : (border ? 6'b111111 : 6'b000000);
    return {c, hs, vs};
  endfunction

  task automatic model_axis(inout int p, inout int d, input int lim, output bit b);
    b = 0;
    if (d > 0) begin
      if (p + 2 >= lim) begin p = lim; d = -1; b = 1; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1; b = 1; end
      else p = p - 2;
    end
  endtask

  task automatic model_tick();
    bit bxb, byb;
    fc = (fc + 1) % 256;
    if (!pause) begin
      model_axis(bx, dx, 608, bxb);
      model_axis(by, dy, 448, byb);
      if (bxb || byb) cidx = (cidx + 1) % 4;
    end
  endtask

  task automatic model_reset();
    bx = 0; by = 0; dx = 1; dy = 1; cidx = 0; fc = 0;
    expq.delete();
    expq.push_back(8'b000000_11);
  endtask

  task automatic cycle(input int px, input int py, input logic act,
                       input logic hs, input logic vs);
    logic [7:0] e;
    x = 10'(px); y = 10'(py); active = act; hsync_in = hs; vsync_in = vs;
    expq.push_back(model_out(px, py, act, hs, vs));
    if (px == 0 && py == 480) model_tick();
    @(posedge clk); #1;
    e = expq.pop_front();
    chk("rgb", rgb, e[7:2]);
    chk("hsync_out", hsync_out, e[1]);
    chk("vsync_out", vsync_out, e[0]);
  endtask

  task automatic rand_pix();
    int px, py;
    logic act;
    if ($urandom % 2 == 0) begin
      px = bx - 2 + int'($urandom_range(0, 36));
      py = by - 2 + int'($urandom_range(0, 36));
      if (px < 0) px = 0;
      if (py < 0) py = 0;
    end else begin
      px = int'($urandom_range(0, 799));
      py = int'($urandom_range(0, 524));
    end
    if (px == 0 && py == 480) py = 481;
    act = (px < 640 && py < 480) ? ($urandom % 8 != 0) : 1'b0;
    cycle(px, py, act, 1'($urandom), 1'($urandom));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_box_x"}, dut.u_axis_x.pos, bx);
    chk({tag, "_box_y"}, dut.u_axis_y.pos, by);
    chk({tag, "_colour_idx"}, dut.colour_idx_q, cidx);
    chk({tag, "_frame_count"}, frame_count, fc);
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0;
    x = '0; y = '0; active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = 10'($urandom_range(0, 799)); y = 10'($urandom_range(0, 524));
      active = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      @(posedge clk); #1;
      chk("reset_rgb", rgb, 0);
      chk("reset_hsync", hsync_out, 1);
      chk("reset_vsync", vsync_out, 1);
      chk("reset_frame_count", frame_count, 0);
    end
    chk("reset_box_x", dut.u_axis_x.pos, 0);
    chk("reset_box_y", dut.u_axis_y.pos, 0);
    rst = 1'b0;
    model_reset();

    // latency/alignment: red box pixel, top border, blanked pixel
    cycle(5, 5, 1'b1, 1'b0, 1'b1);
    cycle(100, 0, 1'b1, 1'b1, 1'b0);
    cycle(200, 200, 1'b0, 1'b1, 1'b1);
    cycle(300, 300, 1'b1, 1'b1, 1'b1);
    cycle(300, 300, 1'b1, 1'b1, 1'b1);

    for (int t = 1; t <= 320; t++) begin
      if (t >= 306 && t <= 308) pause = 1'b1;
      else if (t > 310)         pause = ($urandom % 4 == 0);
      else                      pause = 1'b0;
      cycle(0, 480, 1'b0, 1'($urandom), 1'($urandom));
      pause = 1'b0;
      check_state("tick");
      if (t == 1) begin
        chk("t1_box_x", dut.u_axis_x.pos, 2);
        chk("t1_box_y", dut.u_axis_y.pos, 2);
        chk("t1_frame_count", frame_count, 1);
        cycle(33, 33, 1'b1, 1'b1, 1'b1);
        cycle(0, 1, 1'b1, 1'b1, 1'b1);
      end
      if (t == 224) begin
        chk("t224_box_y", dut.u_axis_y.pos, 448);
        chk("t224_colour_idx", dut.colour_idx_q, 1);
      end
      if (t == 256) chk("t256_frame_wrap", frame_count, 0);
      if (t == 304) begin
        chk("t304_box_x", dut.u_axis_x.pos, 608);
        chk("t304_colour_idx", dut.colour_idx_q, 2);
      end
      if (t == 305 || t == 308) begin
        chk("t305_box_x", dut.u_axis_x.pos, 606);
        chk("t305_box_y", dut.u_axis_y.pos, 286);
      end
      if (t == 308) chk("pause_frame_count", frame_count, 52);
      repeat (4) rand_pix();
    end

    // reset in the middle of the visible area
    x = 10'd100; y = 10'd100; active = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rgb", rgb, 0);
    chk("midrst_hsync", hsync_out, 1);
    chk("midrst_vsync", vsync_out, 1);
    rst = 1'b0;
    model_reset();
    check_state("midrst");
    cycle(5, 5, 1'b1, 1'b0, 1'b0);
    cycle(6, 6, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      cycle(0, 480, 1'b0, 1'b1, 1'b1);
      check_state("post_rst_tick");
      repeat (5) rand_pix();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
